// File: rtl/excp_mret_ctrl.sv
// Trap-return sequencer: waits for mepc to commit, flushes the pipe, then
// redirects fetch to mepc and restores mstatus.MIE from MPIE in one pulse.
module excp_mret_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mret_e,
  input  logic            excp_e,
  input  logic            mepc_wr_pend,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            mpie_in,
  output logic            flush_req,
  output logic            stall_e,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_wen,
  output logic            mie_new,
  output logic            mpie_new,
  output logic            busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0]  PC_MASK  = ~XLEN'(3);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_CSR = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic             mpie_cap_q, mpie_cap_d;
  logic             flush_q, flush_d;
  logic             redir_q, redir_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic             mie_new_q, mie_new_d;
  logic             mpie_new_q, mpie_new_d;
  logic             busy_q, busy_d;

  // State and registered outputs; reset aborts any sequence with no side effect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      mpie_cap_q <= 1'b0;
      flush_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      mie_new_q  <= 1'b0;
      mpie_new_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      mpie_cap_q <= mpie_cap_d;
      flush_q    <= flush_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      mie_new_q  <= mie_new_d;
      mpie_new_q <= mpie_new_d;
      busy_q     <= busy_d;
    end
  end

  // Next state; stall_e is combinational so E holds in the mret cycle itself
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    mpie_cap_d = mpie_cap_q;
    stall_e    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mret_e && !excp_e) begin
          if (mepc_wr_pend) begin
            stall_e = 1'b1;
            state_d = S_WAIT_CSR;
          end else begin
            target_d   = mepc_in & PC_MASK;
            mpie_cap_d = mpie_in;
            cnt_d      = CNT_LOAD;
            state_d    = S_FLUSH;
          end
        end
      end
      S_WAIT_CSR: begin
        if (mepc_wr_pend) begin
          stall_e = 1'b1;
        end else begin
          target_d   = mepc_in & PC_MASK;
          mpie_cap_d = mpie_in;
          cnt_d      = CNT_LOAD;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    flush_d    = (state_d == S_FLUSH) || (state_d == S_REDIRECT);
    redir_d    = (state_d == S_REDIRECT);
    busy_d     = (state_d != S_IDLE);
    redir_pc_d = redir_d ? target_q   : redir_pc_q;
    mie_new_d  = redir_d ? mpie_cap_q : mie_new_q;
    mpie_new_d = redir_d ? 1'b1       : mpie_new_q;
  end

  assign flush_req      = flush_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  assign mstatus_wen    = redir_q;
  assign mie_new        = mie_new_q;
  assign mpie_new       = mpie_new_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_excp_mret_ctrl.sv
// Bench for excp_mret_ctrl: per-cycle control checks in scenario tasks and a
// scoreboard of expected redirect targets popped on every redirect pulse.
module tb_excp_mret_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int F = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            mie;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mret_e = 1'b0;
  logic            excp_e = 1'b0;
  logic            mepc_wr_pend = 1'b0;
  logic [XLEN-1:0] mepc_in = '0;
  logic            mpie_in = 1'b0;
  logic            flush_req, stall_e, redirect_valid, mstatus_wen;
  logic            mie_new, mpie_new, busy;
  logic [XLEN-1:0] redirect_pc;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  logic [XLEN-1:0] last_pc = '0;

  excp_mret_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .reset(rst_n), .mret_e(mret_e), .excp_e(excp_e),
    .mepc_wr_pend(mepc_wr_pend), .mepc_in(mepc_in), .mpie_in(mpie_in),
    .flush_req(flush_req), .stall_e(stall_e), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mstatus_wen(mstatus_wen), .mie_new(mie_new),
    .mpie_new(mpie_new), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every redirect pulse must match the oldest outstanding mret
  always @(negedge clk) begin
    if (rst_n && redirect_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL redirect_unexpected pc=%h", redirect_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({redirect_pc, mie_new, mpie_new, mstatus_wen} !== {e.pc, e.mie, 1'b1, 1'b1}) begin
          bad++;
          $display("FAIL redirect_payload got pc=%h mie=%b mpie=%b wen=%b want pc=%h mie=%b mpie=1 wen=1",
                   redirect_pc, mie_new, mpie_new, mstatus_wen, e.pc, e.mie);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({flush_req, stall_e, redirect_valid, mstatus_wen, mie_new, mpie_new, busy, redirect_pc} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ctl=%b pc=%h want all zero",
               {flush_req, stall_e, redirect_valid, mstatus_wen, mie_new, mpie_new, busy}, redirect_pc);
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  // One mret from acceptance through its redirect cycle; ends at the next drive point
  task automatic run_mret(input logic [XLEN-1:0] stale_pc, input logic [XLEN-1:0] new_pc,
                          input logic mpie, input int pend, input logic hold);
    int   c;
    exp_t e;
    logic [4:0] want;
    c = pend;
    for (int cyc = 0; cyc <= c + F + 1; cyc++) begin
      mret_e       = (cyc == 0) || hold;
      excp_e       = hold && (cyc > 0);
      mepc_wr_pend = (cyc < pend);
      mepc_in      = (cyc < pend) ? stale_pc : ((cyc == c) ? new_pc : 32'hdead_beef);
      mpie_in      = (cyc == c) ? mpie : ~mpie;
      if (cyc == 0) begin
        e.pc  = {new_pc[XLEN-1:2], 2'b00};
        e.mie = mpie;
        sb_q.push_back(e);
        last_pc = e.pc;
      end
      want = {(cyc < pend), (cyc >= c + 1), (cyc >= 1), (cyc == c + F + 1), (cyc == c + F + 1)};
      @(negedge clk);
      total++;
      if ({stall_e, flush_req, busy, redirect_valid, mstatus_wen} !== want) begin
        bad++;
        $display("FAIL mret_ctl cyc=%0d pend=%0d got=%b want=%b (stall,flush,busy,redir,wen)",
                 cyc, pend, {stall_e, flush_req, busy, redirect_valid, mstatus_wen}, want);
      end
      next_cycle();
    end
    mret_e = 1'b0;
    excp_e = 1'b0;
    mepc_wr_pend = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    mret_e = 1'b0;
    excp_e = 1'b0;
    mepc_wr_pend = 1'b0;
    @(negedge clk);
    total++;
    if ({stall_e, flush_req, busy, redirect_valid, mstatus_wen} !== 5'b0 || redirect_pc !== last_pc) begin
      bad++;
      $display("FAIL idle_%s got ctl=%b pc=%h want ctl=00000 pc=%h", tag,
               {stall_e, flush_req, busy, redirect_valid, mstatus_wen}, redirect_pc, last_pc);
    end
    next_cycle();
  endtask

  task automatic test_plain();
    run_mret('0, 32'h0000_001c, 1'b1, 0, 1'b0);
    check_idle("plain");
  endtask

  task automatic test_pending_write();
    run_mret(32'h0000_0018, 32'h0000_0020, 1'b1, 3, 1'b0);
    check_idle("pending");
  endtask

  task automatic test_misaligned();
    run_mret('0, 32'h0000_003e, 1'b1, 0, 1'b0);
    check_idle("misaligned");
  endtask

  task automatic test_mpie_zero();
    run_mret('0, 32'h0000_0040, 1'b0, 0, 1'b0);
    check_idle("mpie0");
  endtask

  task automatic test_exception_priority();
    mret_e = 1'b1;
    excp_e = 1'b1;
    mepc_wr_pend = 1'b1;
    mepc_in = 32'h0000_0080;
    @(negedge clk);
    total++;
    if ({stall_e, flush_req, busy, redirect_valid} !== 4'b0) begin
      bad++;
      $display("FAIL excp_priority got=%b want=0000 (stall,flush,busy,redir)",
               {stall_e, flush_req, busy, redirect_valid});
    end
    next_cycle();
    for (int i = 0; i < 3; i++) check_idle("excp");
  endtask

  task automatic test_reset_mid_flush();
    mret_e = 1'b1;
    mepc_in = 32'h0000_0100;
    mpie_in = 1'b1;
    next_cycle();
    mret_e = 1'b0;
    @(negedge clk);
    total++;
    if (flush_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_flush got=%b want=1", flush_req);
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    total++;
    if ({flush_req, stall_e, redirect_valid, mstatus_wen, mie_new, mpie_new, busy, redirect_pc} !== '0) begin
      bad++;
      $display("FAIL rst_async got ctl=%b pc=%h want all zero",
               {flush_req, stall_e, redirect_valid, mstatus_wen, mie_new, mpie_new, busy}, redirect_pc);
    end
    next_cycle();
    rst_n = 1'b1;
    last_pc = '0;
    for (int i = 0; i < 4; i++) check_idle("after_rst");
    run_mret('0, 32'h0000_0104, 1'b1, 0, 1'b0);
    check_idle("after_rst_mret");
  endtask

  task automatic test_back_to_back();
    run_mret('0, 32'h0000_0200, 1'b1, 0, 1'b1);
    run_mret(32'h0000_0300, 32'h0000_0304, 1'b0, 2, 1'b0);
    run_mret('0, 32'h0000_0401, 1'b1, 0, 1'b0);
    check_idle("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_mret($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end
    check_idle("random");
  endtask

  initial begin
    test_reset();
    test_plain();
    test_pending_write();
    test_misaligned();
    test_mpie_zero();
    test_exception_priority();
    test_reset_mid_flush();
    test_back_to_back();
    test_random();
    for (int i = 0; i < 3; i++) next_cycle();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d outstanding want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/excp_mret_ctrl.md
Name: excp_mret_ctrl

Overview:
Trap-return sequencer for cpu6, the counterpart of the exception-entry path that writes mepc. When an mret reaches the E stage, the block captures mepc once any in-flight CSR write to mepc has committed. It then flushes the pipeline, restores mstatus.MIE from MPIE, and redirects fetch to mepc. It sits between the E-stage decode, the csr unit (mepc/mstatus) and the fetch PC mux.

Parameters:
XLEN, 32, datapath / PC width (matches `CPU6_XLEN)
FLUSH_CYCLES, 2, cycles flush_req is held before the redirect (1..15)

Ports:
clk  input  1  core clock (cpu_clk)
reset  input  1  asynchronous, active-low reset
mret_e  input  1  decoded mret valid in E stage
excp_e  input  1  exception (e.g. excp_illinstr) raised in E stage this cycle
mepc_wr_pend  input  1  a CSR write to mepc is in flight and not yet committed
mepc_in  input  XLEN  current committed mepc from csr
mpie_in  input  1  current mstatus.MPIE
flush_req  output  1  kill F/D/E stage instructions
stall_e  output  1  hold E stage (mret waiting for mepc write)
redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  output  XLEN  trap-return target
mstatus_wen  output  1  one-cycle pulse: csr loads mie_new / mpie_new
mie_new  output  1  new mstatus.MIE (= captured MPIE)
mpie_new  output  1  new mstatus.MPIE (always 1)
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, all outputs 0, redirect_pc=0.
- States: IDLE, WAIT_CSR, FLUSH, REDIRECT.
- IDLE:
  - mret_e=1 and excp_e=1: exception has priority; mret is ignored; stay IDLE, outputs 0.
  - mret_e=1, excp_e=0, mepc_wr_pend=1: go to WAIT_CSR; stall_e=1 combinationally in the same cycle.
  - mret_e=1, excp_e=0, mepc_wr_pend=0: capture target={mepc_in[XLEN-1:2],2'b00} and MPIE; counter=FLUSH_CYCLES-1; go to FLUSH.
- WAIT_CSR:
  - stall_e=1 while mepc_wr_pend=1.
  - First cycle with mepc_wr_pend=0: capture mepc_in and mpie_in as in IDLE, drop stall_e, go to FLUSH. The captured value must be the newly written mepc, never the stale one.
  - mret_e is not re-sampled in this state.
- FLUSH:
  - flush_req=1.
  - Counter decrements each cycle; at 0, go to REDIRECT.
  - Total flush_req high time is FLUSH_CYCLES cycles.
  - mret_e, excp_e and mepc_in are ignored; the target is frozen at capture.
- REDIRECT (exactly one cycle):
  - redirect_valid=1, redirect_pc=captured target.
  - mstatus_wen=1, mie_new=captured MPIE, mpie_new=1.
  - flush_req=1 in this cycle.
  - Next state is IDLE.
- Latency with no pending CSR write: mret_e in cycle N, flush cycles N+1..N+FLUSH_CYCLES, redirect in cycle N+FLUSH_CYCLES+1.
- busy=1 in every state except IDLE.
- redirect_pc keeps its last value outside REDIRECT; consumers qualify it with redirect_valid.
- Back-to-back mret: a new mret_e is accepted only in IDLE, so the earliest next acceptance is the cycle after REDIRECT.
- Reset asserted mid-sequence: immediate return to IDLE. No partial redirect or mstatus write may occur.
- mepc bits [1:0] are always forced to 0 (no compressed ISA).

Test Plan:
- Plain mret: mepc_in=0x0000001c, mpie_in=1, FLUSH_CYCLES=2, mret_e pulse at cycle 10 -> flush_req high cycles 11-13; redirect_valid, mstatus_wen and redirect_pc=0x0000001c at cycle 13; mie_new=1, mpie_new=1; busy low at cycle 14.
- Pending mepc write: mret_e at cycle 5 with mepc_wr_pend=1 for cycles 5-7, mepc_in switching from 0x18 to 0x20 at cycle 8 -> stall_e high cycles 5-7; redirect_pc=0x00000020 in cycle 11, never 0x18.
- Misaligned mepc: mepc_in=0x0000003e -> redirect_pc=0x0000003c.
- Simultaneous mret_e=1 and excp_e=1 -> no flush_req, no redirect, busy stays 0; exception-entry path is unaffected.
- Reset pulled low during FLUSH (cycle 12 of scenario 1) -> all outputs 0 immediately; no redirect pulse after reset releases; a new mret afterwards completes normally.
- mpie_in=0 with mepc_in=0x40 -> mie_new=0, mpie_new=1, redirect_pc=0x40; mpie_in toggled during FLUSH does not change mie_new.
